// File: rtl/mdu_div_sequencer.sv
// ============================================================================
// Module      : mdu_div_sequencer
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU that stalls
//               the EX stage while it works.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             ex_stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_is_rem;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [WIDTH-1:0]    r_dvs;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_result;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects remainder.
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;

    assign w_signed  = ~op[0];
    assign w_a_neg   = w_signed & dividend[WIDTH-1];
    assign w_b_neg   = w_signed & divisor[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_b_mag   = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_div0    = (divisor == '0);
    assign w_ovf     = w_signed & (dividend == c_most_neg) & (divisor == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = op[1] ? dividend : '1;
        else
            w_special_res = op[1] ? '0 : dividend;
    end

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits.
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_final;

    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_dvs};
    assign w_ge        = ~w_diff[WIDTH];
    assign w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_ge};
    assign w_q_fix     = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_r_fix     = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_final     = r_is_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvs    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_rem <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dvs    <= w_b_mag;
                        r_quo    <= w_a_mag;
                        r_rem    <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= c_cnt_w'(WIDTH - 1);
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
                // A start still held here belongs to the op just completed.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ex_stall     = ~rst & ~flush &
                          (((r_state == S_IDLE) & start) | (r_state == S_BUSY));
    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mdu_div_sequencer.sv
// ============================================================================
// Module      : tb_mdu_div_sequencer
// Description : Directed self-checking bench for mdu_div_sequencer with a
//               queue of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_div_sequencer;

    localparam int W = 32;
    localparam logic [1:0] c_div  = 2'b00;
    localparam logic [1:0] c_divu = 2'b01;
    localparam logic [1:0] c_rem  = 2'b10;
    localparam logic [1:0] c_remu = 2'b11;
    localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         ex_stall;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res = '0;

    mdu_div_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        case (o)
            c_div:   model = (b == '0) ? '1 : ((a == c_min && b == '1) ? a : W'(sa / sb));
            c_rem:   model = (b == '0) ? a  : ((a == c_min && b == '1) ? '0 : W'(sa % sb));
            c_divu:  model = (b == '0) ? '1 : a / b;
            default: model = (b == '0) ? a  : a % b;
        endcase
    endfunction

    function automatic int stall_len(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0 || (!o[0] && a == c_min && b == '1))
            stall_len = 1;
        else
            stall_len = W + 1;
    endfunction

    // Called at a falling edge; with keep=1 start stays high so the next call
    // presents its op in the cycle right after DONE.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit keep);
        int stalls = 0;
        bit got = 0;
        logic [W-1:0] e;
        exp_q.push_back(model(o, a, b));
        start = 1'b1; op = o; dividend = a; divisor = b;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (result_valid) begin
                got = 1'b1;
                e = exp_q.pop_front();
                check({tag, " result"}, result, e);
                check({tag, " stall cycles"}, W'(stalls), W'(stall_len(o, a, b)));
                check({tag, " ex_stall in DONE"}, W'(ex_stall), '0);
                last_res = e;
                if (!keep) start = 1'b0;
            end else if (ex_stall) begin
                stalls++;
            end
            @(negedge clk);
        end
        if (!got) begin
            check({tag, " timeout"}, W'(got), W'(1));
            void'(exp_q.pop_front());
        end else if (!keep) begin
            #1;
            check({tag, " valid one cycle"}, W'(result_valid), '0);
            check({tag, " result held"}, result, last_res);
            @(negedge clk);
        end
    endtask

    task automatic no_valid_window(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (result_valid) seen++;
        end
        check(tag, W'(seen), '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = c_divu; dividend = 100; divisor = 7; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ex_stall", W'(ex_stall), '0);
        check("reset busy", W'(busy), '0);
        check("reset result", result, '0);
        check("reset valid", W'(result_valid), '0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        do_op("divu 100/7", c_divu, 100, 7, 1'b0);
        do_op("remu 100/7", c_remu, 100, 7, 1'b0);
        do_op("div -7/2",   c_div, -32'sd7, 2, 1'b0);
        do_op("rem -7/2",   c_rem, -32'sd7, 2, 1'b0);
        do_op("div 7/-2",   c_div, 7, -32'sd2, 1'b0);
        do_op("rem 7/-2",   c_rem, 7, -32'sd2, 1'b0);
        do_op("divu 5/0",   c_divu, 5, 0, 1'b0);
        do_op("remu 5/0",   c_remu, 5, 0, 1'b0);
        do_op("div x/0",    c_div, -32'sd9, 0, 1'b0);
        do_op("div ovf",    c_div, c_min, '1, 1'b0);
        do_op("rem ovf",    c_rem, c_min, '1, 1'b0);
        do_op("divu min/-1", c_divu, c_min, '1, 1'b0);
        do_op("divu max/1", c_divu, '1, 1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            do_op("random", 2'(k % 4), W'($urandom), W'($urandom_range(1, 50000)), 1'b0);
        end

        do_op("b2b first",  c_divu, 1000, 9, 1'b1);
        do_op("b2b second", c_divu, 77777, 123, 1'b0);

        // Flush in the tenth BUSY cycle.
        start = 1'b1; op = c_divu; dividend = 1000; divisor = 3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush ex_stall", W'(ex_stall), '0);
        check("flush busy before", W'(busy), W'(1));
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush idle next", W'(busy), '0);
        check("flush result held", result, last_res);
        no_valid_window("flush no valid", 40);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; op = c_div; dividend = -32'sd12345; divisor = 11;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst ex_stall", W'(ex_stall), '0);
        @(negedge clk);
        #1;
        check("rst busy", W'(busy), '0);
        check("rst result", result, '0);
        check("rst valid", W'(result_valid), '0);
        rst = 1'b0; start = 1'b0;
        no_valid_window("rst no valid", 40);

        check("scoreboard empty", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
